// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: wraps a 16-bit payload stream as SOF, HDR(seq), payload,
// checksum, EOF, with idle fill between frames and on payload underrun.
module tlk2711_tx_framer #(
    parameter int MAX_LEN   = 1024,
    parameter int GAP_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tx_en,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [15:0] o_txd,
    output logic        o_tkmsb,
    output logic        o_tklsb,
    output logic        o_frame_done,
    output logic        o_underrun,
    output logic        o_len_err,
    output logic [15:0] o_seq
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SOF, ST_HDR, ST_PAYLOAD, ST_CSUM, ST_EOF, ST_GAP, ST_DROP
    } state_t;

    localparam logic [15:0] W_IDLE    = 16'hC5BC;
    localparam logic [15:0] W_SOF     = 16'h50FB;
    localparam logic [15:0] W_EOF     = 16'h50FD;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);
    localparam logic [15:0] GAP_W     = 16'(GAP_WORDS);

    state_t      state, state_nxt;
    logic [15:0] csum, csum_nxt;
    logic [15:0] wcnt, wcnt_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic        drop, drop_nxt;
    logic [15:0] seq, seq_nxt;
    logic [15:0] txd_nxt;
    logic        tkmsb_nxt, tklsb_nxt;
    logic        done_nxt, under_nxt, len_err_nxt;
    logic        start_ok;

    assign start_ok = i_tx_en & s_valid;
    assign s_ready  = (state == ST_PAYLOAD) || (state == ST_DROP);
    assign o_seq    = seq;

    always_comb begin
        state_nxt   = state;
        csum_nxt    = csum;
        wcnt_nxt    = wcnt;
        gap_nxt     = (gap_cnt != 16'd0) ? gap_cnt - 16'd1 : gap_cnt;
        drop_nxt    = drop;
        seq_nxt     = seq;
        txd_nxt     = W_IDLE;
        tkmsb_nxt   = 1'b0;
        tklsb_nxt   = 1'b1;
        done_nxt    = 1'b0;
        under_nxt   = 1'b0;
        len_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok && gap_cnt == 16'd0)
                    state_nxt = ST_SOF;
            end
            ST_SOF: begin
                txd_nxt   = W_SOF;
                state_nxt = ST_HDR;
            end
            ST_HDR: begin
                txd_nxt   = seq;
                tklsb_nxt = 1'b0;
                state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (s_valid) begin
                    txd_nxt   = s_data;
                    tklsb_nxt = 1'b0;
                    csum_nxt  = csum + s_data;
                    wcnt_nxt  = wcnt + 16'd1;
                    if (s_last) begin
                        state_nxt = ST_CSUM;
                    end else if ({1'b0, wcnt} + 17'd1 == MAX_LEN_W) begin
                        state_nxt   = ST_CSUM;
                        len_err_nxt = 1'b1;
                        drop_nxt    = 1'b1;
                    end
                end else begin
                    under_nxt = 1'b1;
                end
            end
            ST_CSUM: begin
                txd_nxt   = csum;
                tklsb_nxt = 1'b0;
                state_nxt = ST_EOF;
            end
            ST_EOF: begin
                txd_nxt   = W_EOF;
                done_nxt  = 1'b1;
                seq_nxt   = seq + 16'd1;
                csum_nxt  = 16'd0;
                wcnt_nxt  = 16'd0;
                gap_nxt   = GAP_W;
                drop_nxt  = 1'b0;
                state_nxt = drop ? ST_DROP : ST_GAP;
            end
            ST_DROP: begin
                if (s_valid && s_last)
                    state_nxt = ST_GAP;
            end
            ST_GAP: begin
                // The GAP word on the last count is itself the final idle, so a ready
                // frame launches straight to SOF to keep the gap at exactly GAP_WORDS.
                if (gap_cnt <= 16'd1)
                    state_nxt = start_ok ? ST_SOF : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            csum         <= 16'd0;
            wcnt         <= 16'd0;
            gap_cnt      <= 16'd0;
            drop         <= 1'b0;
            seq          <= 16'd0;
            o_txd        <= W_IDLE;
            o_tkmsb      <= 1'b0;
            o_tklsb      <= 1'b1;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            csum         <= csum_nxt;
            wcnt         <= wcnt_nxt;
            gap_cnt      <= gap_nxt;
            drop         <= drop_nxt;
            seq          <= seq_nxt;
            o_txd        <= txd_nxt;
            o_tkmsb      <= tkmsb_nxt;
            o_tklsb      <= tklsb_nxt;
            o_frame_done <= done_nxt;
            o_underrun   <= under_nxt;
            o_len_err    <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer: expected framed words are queued when a frame
// is driven and popped by a monitor as SOF..EOF words appear on the TLK2711 bus.
module tb_tlk2711_tx_framer;

    localparam int MAXL = 4;
    localparam int GAP  = 4;
    localparam logic [15:0] W_IDLE = 16'hC5BC;
    localparam logic [15:0] W_SOF  = 16'h50FB;
    localparam logic [15:0] W_EOF  = 16'h50FD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_tx_en = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [15:0] o_txd;
    logic        o_tkmsb, o_tklsb;
    logic        o_frame_done, o_underrun, o_len_err;
    logic [15:0] o_seq;

    tlk2711_tx_framer #(.MAX_LEN(MAXL), .GAP_WORDS(GAP)) dut (
        .clk(clk), .rst(rst), .i_tx_en(i_tx_en),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .o_txd(o_txd), .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb),
        .o_frame_done(o_frame_done), .o_underrun(o_underrun), .o_len_err(o_len_err),
        .o_seq(o_seq)
    );

    always #6 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [17:0] exp_q[$];       // {tkmsb, tklsb, txd}
    logic [15:0] pl[$];
    logic [15:0] exp_seq = 16'd0;
    bit          in_frame = 1'b0;
    int          idle_run = 0, last_gap = -1;
    int          n_done = 0, n_under = 0, n_lenerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: timed out", tag);
    endtask

    // Monitor: framed words against the scoreboard, pulse counts, idle gap length.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_frame = 1'b0;
            idle_run = 0;
        end else begin
            n_done   += int'(o_frame_done);
            n_under  += int'(o_underrun);
            n_lenerr += int'(o_len_err);
            if (!in_frame && o_txd == W_SOF && o_tklsb) begin
                in_frame = 1'b1;
                last_gap = idle_run;
            end
            if (in_frame) begin
                if (exp_q.size() == 0)
                    timeout("unexpected_frame_word");
                else
                    check("frame_word", 32'({o_tkmsb, o_tklsb, o_txd}), 32'(exp_q.pop_front()));
                if (o_txd == W_EOF && o_tklsb) begin
                    check("done_with_eof", 32'(o_frame_done), 32'd1);
                    in_frame = 1'b0;
                    idle_run = 0;
                end
            end else if (o_txd == W_IDLE && o_tklsb) begin
                idle_run++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 100; i++) begin
            acc = s_ready;
            cyc();
            if (acc) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        timeout("beat_accept");
    endtask

    // Expected words for the frame in pl: truncated at MAXL, fills after beat stall_at.
    task automatic push_exp(input int stall_at, input int stall_n);
        logic [15:0] cs;
        int keep;
        cs   = 16'd0;
        keep = (pl.size() > MAXL) ? MAXL : pl.size();
        exp_q.push_back({2'b01, W_SOF});
        exp_q.push_back({2'b00, exp_seq});
        for (int i = 0; i < keep; i++) begin
            exp_q.push_back({2'b00, pl[i]});
            cs += pl[i];
            if (i == stall_at)
                repeat (stall_n) exp_q.push_back({2'b01, W_IDLE});
        end
        exp_q.push_back({2'b00, cs});
        exp_q.push_back({2'b01, W_EOF});
        exp_seq++;
    endtask

    task automatic send_frame(input int stall_at, input int stall_n);
        push_exp(stall_at, stall_n);
        for (int i = 0; i < pl.size(); i++) begin
            beat(pl[i], i == pl.size() - 1);
            if (i == stall_at) repeat (stall_n) cyc();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !in_frame) return;
            cyc();
        end
        timeout("frame_drain");
    endtask

    initial begin
        int base;
        repeat (3) cyc();
        check("rst_txd", 32'(o_txd), 32'(W_IDLE));
        check("rst_tklsb", 32'(o_tklsb), 32'd1);
        check("rst_tkmsb", 32'(o_tkmsb), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_seq", 32'(o_seq), 32'd0);
        check("rst_pulses", 32'({o_frame_done, o_underrun, o_len_err}), 32'd0);
        rst = 1'b0;
        i_tx_en = 1'b1;

        // Basic 3-beat frame straight out of reset.
        pl = '{16'h0001, 16'h0002, 16'h0003};
        send_frame(-1, 0);
        drain();
        check("frame1_done_cnt", 32'(n_done), 32'd1);
        check("frame1_seq", 32'(o_seq), 32'(exp_seq));

        // Back-to-back frames; second one wraps the checksum.
        pl = '{16'h0010, 16'h0020};
        send_frame(-1, 0);
        pl = '{16'hFFFF, 16'h0002};
        send_frame(-1, 0);
        drain();
        check("b2b_gap", 32'(last_gap), 32'(GAP));
        check("b2b_seq", 32'(o_seq), 32'(exp_seq));

        // Two-cycle underrun between beats 1 and 2.
        base = n_under;
        pl = '{16'h0001, 16'h0002, 16'h0003};
        send_frame(0, 2);
        drain();
        check("underrun_cnt", 32'(n_under - base), 32'd2);

        // Over-length frame: truncated at MAXL, tail dropped, next frame intact.
        base = n_lenerr;
        pl = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
        send_frame(-1, 0);
        drain();
        check("len_err_cnt", 32'(n_lenerr - base), 32'd1);
        pl = '{16'h000A, 16'h000B};
        send_frame(-1, 0);
        drain();
        check("after_drop_seq", 32'(o_seq), 32'(exp_seq));

        // s_last exactly on beat MAXL terminates normally.
        base = n_lenerr;
        pl = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        send_frame(-1, 0);
        drain();
        check("exact_max_no_len_err", 32'(n_lenerr - base), 32'd0);

        // Disabled: valid data must not start a frame.
        i_tx_en = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("dis_txd", 32'(o_txd), 32'(W_IDLE));
            check("dis_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;

        // Enable dropped mid-payload: frame completes, no new SOF.
        base = n_done;
        i_tx_en = 1'b1;
        pl = '{16'h0007, 16'h0008, 16'h0009};
        push_exp(-1, 0);
        beat(16'h0007, 1'b0);
        i_tx_en = 1'b0;
        beat(16'h0008, 1'b0);
        beat(16'h0009, 1'b1);
        s_valid = 1'b1;
        repeat (20) cyc();
        check("en_drop_queue_empty", 32'(exp_q.size()), 32'd0);
        check("en_drop_done", 32'(n_done - base), 32'd1);
        check("en_drop_idle", 32'(o_txd), 32'(W_IDLE));
        s_valid = 1'b0;
        i_tx_en = 1'b1;

        // Reset during payload.
        pl = '{16'h0005, 16'h0006, 16'h0007};
        push_exp(-1, 0);
        beat(16'h0005, 1'b0);
        beat(16'h0006, 1'b0);
        rst = 1'b1;
        cyc();
        check("midrst_txd", 32'(o_txd), 32'(W_IDLE));
        check("midrst_tklsb", 32'(o_tklsb), 32'd1);
        check("midrst_ready", 32'(s_ready), 32'd0);
        check("midrst_seq", 32'(o_seq), 32'd0);
        rst = 1'b0;
        exp_seq = 16'd0;
        pl = '{16'h0021, 16'h0022};
        send_frame(-1, 0);
        drain();
        check("post_rst_seq", 32'(o_seq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
